// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - state/status encodings and default sizing for the MAC sequencer
package mac_seq_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int AW_DEF     = 3;
  localparam int RD_LAT_DEF = 1;
  localparam int TO_MAX_DEF = 15;

  // Encodings double as the status code shown on the debug display.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_READ  = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/mac_seq_cnt.sv
// rtl/mac_seq_cnt.sv - loadable down-counter with zero flag
module mac_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - walks operand SRAMs and hands operand pairs to the FP MAC
// Optional watchdog and ERR state are built when MAC_SEQ_TIMEOUT_EN is defined.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
`ifdef MAC_SEQ_TIMEOUT_EN
  ,
  parameter int TO_MAX = TO_MAX_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          sram_cs_n,
  output logic          sram_oe_n,
  output logic [AW-1:0] sram_addr,
  output logic          acc_clr,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          op_last,
  input  logic          mac_idle,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    state_code
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        st, nxt;
  logic [AW-1:0] addr_nxt;
  logic          lat_zero;

  // Held loaded outside READ so every READ visit starts a fresh RD_LAT count.
  mac_seq_cnt #(.W(LW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (st != S_READ),
    .dec      (st == S_READ),
    .load_val (LW'(RD_LAT - 1)),
    .zero     (lat_zero)
  );

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = (TO_MAX > 1) ? $clog2(TO_MAX) : 1;
  logic stall, wd_zero;

  assign stall = ((st == S_ISSUE) && !op_ready) || ((st == S_DRAIN) && !mac_idle);

  mac_seq_cnt #(.W(TW)) u_wd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!stall),
    .dec      (stall),
    .load_val (TW'(TO_MAX - 1)),
    .zero     (wd_zero)
  );
`endif

  always_comb begin
    nxt      = st;
    addr_nxt = sram_addr;
    case (st)
      S_IDLE:  if (start) begin nxt = S_CLR; addr_nxt = '0; end
      S_CLR:   nxt = S_READ;
      S_READ:  if (lat_zero) nxt = S_ISSUE;
      S_ISSUE: if (op_ready) begin
                 if (sram_addr == LAST) begin
                   nxt = S_DRAIN;
                 end else begin
                   nxt      = S_READ;
                   addr_nxt = sram_addr + 1'b1;
                 end
               end
      S_DRAIN: if (mac_idle) nxt = S_DONE;
      S_DONE:  begin nxt = S_IDLE; addr_nxt = '0; end
`ifdef MAC_SEQ_TIMEOUT_EN
      S_ERR:   if (start) begin nxt = S_CLR; addr_nxt = '0; end
`endif
      default: nxt = S_IDLE;
    endcase
`ifdef MAC_SEQ_TIMEOUT_EN
    if (stall && wd_zero) nxt = S_ERR;
`endif
    if (abort) begin
      nxt      = S_IDLE;
      addr_nxt = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      sram_addr <= '0;
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      acc_clr   <= 1'b0;
      op_valid  <= 1'b0;
      op_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      st        <= nxt;
      sram_addr <= addr_nxt;
      sram_cs_n <= !((nxt == S_READ) || (nxt == S_ISSUE));
      sram_oe_n <= !((nxt == S_READ) || (nxt == S_ISSUE));
      acc_clr   <= (nxt == S_CLR);
      op_valid  <= (nxt == S_ISSUE);
      op_last   <= (nxt == S_ISSUE) && (addr_nxt == LAST);
      busy      <= (nxt != S_IDLE);
      done      <= (nxt == S_DONE);
`ifdef MAC_SEQ_TIMEOUT_EN
      if (nxt == S_ERR) err <= 1'b1;
      else if (nxt == S_CLR) err <= 1'b0;
`endif
    end
  end

`ifndef MAC_SEQ_TIMEOUT_EN
  assign err = 1'b0;
`endif

  assign state_code = st;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

  localparam int DEPTH  = 8;
  localparam int RD_LAT = 1;
  localparam int TO_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       op_ready = 1'b1;
  logic       mac_idle = 1'b1;
  logic       sram_cs_n, sram_oe_n, acc_clr, op_valid, op_last, busy, done, err;
  logic [2:0] sram_addr;
  logic [2:0] state_code;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0, last_cnt = 0, done_cnt = 0;
  int mode = 0;
  int bp_left = 0;
  bit noise = 1'b0;

  // Reference model: phase numbers are the spec's status codes
  int m_ph = 0, m_idx = 0, m_wait = 0, m_stall = 0;
  int m_err = 0;

  mac_seq_ctrl #(.DEPTH(DEPTH), .AW(3), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .sram_cs_n  (sram_cs_n),
    .sram_oe_n  (sram_oe_n),
    .sram_addr  (sram_addr),
    .acc_clr    (acc_clr),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_last    (op_last),
    .mac_idle   (mac_idle),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state_code (state_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_idx <= 0; m_wait <= 0; m_stall <= 0; m_err <= 0;
    end else if (abort) begin
      m_ph <= 0; m_idx <= 0; m_stall <= 0;
    end else begin
      case (m_ph)
        0, 6: if (start) begin m_ph <= 1; m_idx <= 0; m_err <= 0; end
        1: begin m_ph <= 2; m_wait <= RD_LAT; end
        2: if (m_wait <= 1) m_ph <= 3; else m_wait <= m_wait - 1;
        3: if (op_ready) begin
             if (m_idx == DEPTH - 1) m_ph <= 4;
             else begin m_idx <= m_idx + 1; m_ph <= 2; m_wait <= RD_LAT; end
           end
        4: if (mac_idle) m_ph <= 5;
        5: begin m_ph <= 0; m_idx <= 0; end
        default: m_ph <= 0;
      endcase
`ifdef MAC_SEQ_TIMEOUT_EN
      if ((m_ph == 3 && !op_ready) || (m_ph == 4 && !mac_idle)) begin
        if (m_stall + 1 == TO_MAX) begin m_ph <= 6; m_err <= 1; m_stall <= 0; end
        else m_stall <= m_stall + 1;
      end else begin
        m_stall <= 0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    chk("state_code", state_code, m_ph);
    chk("sram_cs_n", sram_cs_n, (m_ph == 2 || m_ph == 3) ? 0 : 1);
    chk("sram_oe_n", sram_oe_n, (m_ph == 2 || m_ph == 3) ? 0 : 1);
    chk("acc_clr", acc_clr, m_ph == 1);
    chk("op_valid", op_valid, m_ph == 3);
    chk("op_last", op_last, m_ph == 3 && m_idx == DEPTH - 1);
    chk("busy", busy, m_ph != 0);
    chk("done", done, m_ph == 5);
    chk("err", err, m_err);
    if (m_ph == 2 || m_ph == 3) chk("sram_addr", sram_addr, m_idx);
    if (op_valid && op_ready) begin
      hs_cnt++;
      if (op_last) last_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic drive();
    case (mode)
      0: begin op_ready = 1'b1; mac_idle = 1'b1; end
      1: begin
        mac_idle = 1'b1;
        if (state_code == 3 && sram_addr == 3 && bp_left > 0) begin
          op_ready = 1'b0; bp_left--;
        end else begin
          op_ready = 1'b1;
        end
      end
      2: begin
        op_ready = ($urandom_range(0, 3) != 0);
        mac_idle = ($urandom_range(0, 1) == 1);
      end
      default: begin op_ready = 1'b1; mac_idle = 1'b0; end
    endcase
    if (noise) start = busy && ($urandom_range(0, 2) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int budget, output int cyc, output int acc_cyc);
    cyc = 0;
    acc_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (acc_clr && acc_cyc < 0) acc_cyc = cyc;
      if (done || cyc >= budget) break;
      tick();
      cyc++;
    end
    chk("run_done_seen", done, 1);
  endtask

  task automatic wait_for(input int code, input int a, input bit use_a, input int budget,
                          input string nm);
    int n = 0;
    while (!(state_code == code && (!use_a || sram_addr == a)) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, (state_code == code && (!use_a || sram_addr == a)) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc, acc_cyc, hs0, last0, done0;
    tick();
    tick();
    chk("rst_cs_n", sram_cs_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_state", state_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    mode = 0;
    hs0 = hs_cnt; last0 = last_cnt;
    run(100, cyc, acc_cyc);
    chk("nominal_acc_clr_cycle", acc_cyc, 1);
    chk("nominal_done_cycle", cyc, 19);
    tick();
    chk("nominal_handshakes", hs_cnt - hs0, 8);
    chk("nominal_op_last", last_cnt - last0, 1);
    chk("nominal_idle_after", busy, 0);

    mode = 1; bp_left = 4;
    hs0 = hs_cnt;
    run(100, cyc, acc_cyc);
    chk("backpressure_done_cycle", cyc, 23);
    tick();
    chk("backpressure_handshakes", hs_cnt - hs0, 8);

    mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(2, 6, 1'b1, 60, "abort_reach_read6");
    done0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_state", state_code, 0);
    chk("abort_busy", busy, 0);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - done0, 0);
    hs0 = hs_cnt;
    run(100, cyc, acc_cyc);
    chk("restart_done_cycle", cyc, 19);
    tick();
    chk("restart_handshakes", hs_cnt - hs0, 8);

    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_state", state_code, 0);
    chk("start_abort_idle_busy", busy, 0);
    tick();

    for (int r = 0; r < 6; r++) begin
      mode = (r == 0) ? 0 : 2;
      noise = 1'b1;
      hs0 = hs_cnt; last0 = last_cnt;
      run(400, cyc, acc_cyc);
      noise = 1'b0; start = 1'b0;
      tick(); tick();
      chk("random_handshakes", hs_cnt - hs0, 8);
      chk("random_op_last", last_cnt - last0, 1);
    end

`ifdef MAC_SEQ_TIMEOUT_EN
    mode = 3;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(4, 0, 1'b0, 60, "timeout_reach_drain");
    begin
      int n = 0;
      while (state_code != 6 && n < 50) begin tick(); n++; end
      chk("timeout_cycles", n, TO_MAX);
    end
    chk("timeout_err", err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("timeout_restart_err", err, 0);
    chk("timeout_restart_state", state_code, 1);
    mode = 0;
    wait_for(5, 0, 1'b0, 60, "timeout_rerun_done");
    tick();
`endif

    mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(3, 5, 1'b1, 60, "reset_reach_issue5");
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_cs_n", sram_cs_n, 1);
    chk("midrun_rst_addr", sram_addr, 0);
    chk("midrun_rst_state", state_code, 0);
    chk("midrun_rst_op_valid", op_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
